// File: rtl/buzzer_tone_player.sv
// Square-wave buzzer driver: plays one note (divider preset + beat count) per
// valid/ready handshake, then holds a silent articulation gap and pulses note_done.
module buzzer_tone_player #(
    parameter int CNT_WIDTH  = 14,
    parameter int PRE_DIV    = 12,
    parameter int BEAT_DIV   = 3_000_000,
    parameter int DUR_WIDTH  = 8,
    parameter int GAP_CYCLES = 600_000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [CNT_WIDTH-1:0] note_origin,
    input  logic [DUR_WIDTH-1:0] note_dur,
    input  logic                 note_valid,
    output logic                 note_ready,
    output logic                 speaker,
    output logic                 busy,
    output logic                 note_done
);

    localparam int PRE_W  = (PRE_DIV > 1)    ? $clog2(PRE_DIV)    : 1;
    localparam int BEAT_W = (BEAT_DIV > 1)   ? $clog2(BEAT_DIV)   : 1;
    localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [CNT_WIDTH-1:0] TONE_MAX  = '1;
    localparam logic [PRE_W-1:0]     PRE_LAST  = PRE_W'(PRE_DIV - 1);
    localparam logic [BEAT_W-1:0]    BEAT_LAST = BEAT_W'(BEAT_DIV - 1);
    localparam logic [GAP_W-1:0]     GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [DUR_WIDTH-1:0] DUR_ONE   = DUR_WIDTH'(1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PLAY = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    logic [1:0]           state_q,      state_d;
    logic [CNT_WIDTH-1:0] preset_q,     preset_d;
    logic [CNT_WIDTH-1:0] tone_cnt_q,   tone_cnt_d;
    logic [PRE_W-1:0]     pre_cnt_q,    pre_cnt_d;
    logic [BEAT_W-1:0]    beat_cnt_q,   beat_cnt_d;
    logic [DUR_WIDTH-1:0] beats_left_q, beats_left_d;
    logic [GAP_W-1:0]     gap_cnt_q,    gap_cnt_d;
    logic                 speaker_q,    speaker_d;
    logic                 note_done_q,  note_done_d;

    logic pre_step;
    logic beat_wrap;

    assign note_ready = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign speaker    = speaker_q;
    assign note_done  = note_done_q;

    assign pre_step  = (pre_cnt_q == PRE_LAST);
    assign beat_wrap = (beat_cnt_q == BEAT_LAST);

    // NOTE: every *_d gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d      = state_q;
        preset_d     = preset_q;
        tone_cnt_d   = tone_cnt_q;
        pre_cnt_d    = pre_cnt_q;
        beat_cnt_d   = beat_cnt_q;
        beats_left_d = beats_left_q;
        gap_cnt_d    = gap_cnt_q;
        speaker_d    = speaker_q;
        note_done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                speaker_d = 1'b0;
                if (note_valid) begin
                    preset_d     = note_origin;
                    tone_cnt_d   = note_origin;
                    beats_left_d = (note_dur == '0) ? DUR_ONE : note_dur;
                    pre_cnt_d    = '0;
                    beat_cnt_d   = '0;
                    state_d      = ST_PLAY;
                end
            end

            ST_PLAY: begin
                pre_cnt_d  = pre_step ? '0 : pre_cnt_q + PRE_W'(1);
                beat_cnt_d = beat_wrap ? '0 : beat_cnt_q + BEAT_W'(1);

                // A rest preset sits at terminal count and must never toggle.
                if (pre_step && (preset_q != TONE_MAX)) begin
                    if (tone_cnt_q == TONE_MAX) begin
                        tone_cnt_d = preset_q;
                        speaker_d  = ~speaker_q;
                    end else begin
                        tone_cnt_d = tone_cnt_q + CNT_WIDTH'(1);
                    end
                end

                // Duration expiry overrides a coincident toggle.
                if (beat_wrap) begin
                    beats_left_d = beats_left_q - DUR_ONE;
                    if (beats_left_q == DUR_ONE) begin
                        state_d   = ST_GAP;
                        speaker_d = 1'b0;
                        gap_cnt_d = '0;
                    end
                end
            end

            ST_GAP: begin
                speaker_d = 1'b0;
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d   = '0;
                    state_d     = ST_IDLE;
                    note_done_d = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end

            default: begin
                state_d   = ST_IDLE;
                speaker_d = 1'b0;
            end
        endcase
    end

    // NOTE: state updates use non-blocking assignments so all flops sample the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            preset_q     <= '0;
            tone_cnt_q   <= '0;
            pre_cnt_q    <= '0;
            beat_cnt_q   <= '0;
            beats_left_q <= '0;
            gap_cnt_q    <= '0;
            speaker_q    <= 1'b0;
            note_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            preset_q     <= preset_d;
            tone_cnt_q   <= tone_cnt_d;
            pre_cnt_q    <= pre_cnt_d;
            beat_cnt_q   <= beat_cnt_d;
            beats_left_q <= beats_left_d;
            gap_cnt_q    <= gap_cnt_d;
            speaker_q    <= speaker_d;
            note_done_q  <= note_done_d;
        end
    end

endmodule

// File: tb/tb_buzzer_tone_player.sv
// Directed bench for buzzer_tone_player: one instance with PRE_DIV=1, one with PRE_DIV=3,
// both with BEAT_DIV=16 and GAP_CYCLES=2.
module tb_buzzer_tone_player;

    logic        clk;
    logic        rst_n;
    logic [13:0] note_origin;
    logic [7:0]  note_dur;
    logic        nv1, nv3;
    logic        rdy1, spk1, busy1, done1;
    logic        rdy3, spk3, busy3, done3;

    int total = 0;
    int bad   = 0;

    buzzer_tone_player #(
        .CNT_WIDTH(14), .PRE_DIV(1), .BEAT_DIV(16), .DUR_WIDTH(8), .GAP_CYCLES(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .note_origin(note_origin), .note_dur(note_dur),
        .note_valid(nv1), .note_ready(rdy1), .speaker(spk1), .busy(busy1), .note_done(done1)
    );

    buzzer_tone_player #(
        .CNT_WIDTH(14), .PRE_DIV(3), .BEAT_DIV(16), .DUR_WIDTH(8), .GAP_CYCLES(2)
    ) dut3 (
        .clk(clk), .rst_n(rst_n), .note_origin(note_origin), .note_dur(note_dur),
        .note_valid(nv3), .note_ready(rdy3), .speaker(spk3), .busy(busy3), .note_done(done3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int observed, input int expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Plays one note on the selected instance; sample k is taken just after edge k,
    // where edge 0 is the accepting edge.
    task automatic run_note(input bit sel, input logic [13:0] pre, input logic [7:0] dur,
                            input int half, input int n_chk, input int limit,
                            output int first_t, output int trans, output int busy_n,
                            output int done_e, output int done_n, output int spacing_bad,
                            output int spk_end);
        logic s, b, d, prev;
        int   last;
        note_origin = pre;
        note_dur    = dur;
        if (sel) nv3 = 1'b1; else nv1 = 1'b1;
        step_clk();
        nv1 = 1'b0;
        nv3 = 1'b0;
        first_t = -1; trans = 0; busy_n = 0; done_e = -1; done_n = 0; spacing_bad = 0;
        prev = 1'b0; last = 0; s = 1'b0;
        for (int k = 0; k < limit; k++) begin
            if (k > 0) step_clk();
            s = sel ? spk3  : spk1;
            b = sel ? busy3 : busy1;
            d = sel ? done3 : done1;
            if (b) busy_n++;
            if (d) begin
                done_n++;
                if (done_e < 0) done_e = k;
            end
            if (s !== prev) begin
                trans++;
                if (first_t < 0) first_t = k;
                else if (trans <= n_chk && (k - last) != half) spacing_bad++;
                last = k;
                prev = s;
            end
            if (done_e >= 0 && k >= done_e + 2) break;
        end
        spk_end = int'(s);
    endtask

    initial begin
        int first_t, trans, busy_n, done_e, done_n, spacing_bad, spk_end;
        int busy_a, trans_a, ready_bad, got_done;
        int first_b, done_b;
        logic prev;

        rst_n = 1'b0; nv1 = 1'b0; nv3 = 1'b0; note_origin = '0; note_dur = '0;
        #12;
        check("reset_speaker", int'(spk1), 0);
        check("reset_busy",    int'(busy1), 0);
        check("reset_ready",   int'(rdy1), 1);
        check("reset_done",    int'(done1), 0);
        #10 rst_n = 1'b1;
        step_clk();

        // Reset mid-PLAY: speaker is high after edge 12 of a 4-clock half-period tone.
        note_origin = 14'd16380; note_dur = 8'd2; nv1 = 1'b1;
        step_clk();
        nv1 = 1'b0;
        repeat (12) step_clk();
        check("midplay_speaker_high", int'(spk1), 1);
        check("midplay_busy",         int'(busy1), 1);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_speaker", int'(spk1), 0);
        check("async_rst_busy",    int'(busy1), 0);
        check("async_rst_ready",   int'(rdy1), 1);
        #4 rst_n = 1'b1;
        step_clk();

        // Tone after reset release: preset 16380, 2 beats.
        run_note(1'b0, 14'd16380, 8'd2, 4, 8, 60,
                 first_t, trans, busy_n, done_e, done_n, spacing_bad, spk_end);
        check("tone_first_toggle", first_t, 4);
        check("tone_transitions",  trans, 8);
        check("tone_spacing_bad",  spacing_bad, 0);
        check("tone_busy_cycles",  busy_n, 34);
        check("tone_done_sample",  done_e, 34);
        check("tone_done_pulses",  done_n, 1);
        check("tone_speaker_end",  spk_end, 0);

        // Rest: preset at terminal count never toggles.
        run_note(1'b0, 14'd16383, 8'd1, 1, 0, 60,
                 first_t, trans, busy_n, done_e, done_n, spacing_bad, spk_end);
        check("rest_transitions", trans, 0);
        check("rest_busy_cycles", busy_n, 18);
        check("rest_done_sample", done_e, 18);
        check("rest_done_pulses", done_n, 1);

        // Zero duration behaves as one beat.
        run_note(1'b0, 14'd16382, 8'd0, 2, 8, 60,
                 first_t, trans, busy_n, done_e, done_n, spacing_bad, spk_end);
        check("zdur_first_toggle", first_t, 2);
        check("zdur_transitions",  trans, 8);
        check("zdur_spacing_bad",  spacing_bad, 0);
        check("zdur_busy_cycles",  busy_n, 18);
        check("zdur_done_pulses",  done_n, 1);

        // Handshake: valid held high with scrambled fields while busy, then back-to-back.
        note_origin = 14'd16380; note_dur = 8'd1; nv1 = 1'b1;
        step_clk();
        busy_a = 0; trans_a = 0; ready_bad = 0; got_done = 0; prev = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (k > 0) step_clk();
            if (done1) begin
                got_done = 1;
                break;
            end
            if (busy1) busy_a++;
            if (rdy1) ready_bad++;
            if (spk1 !== prev) begin
                trans_a++;
                prev = spk1;
            end
            note_origin = 14'(16383 - (k % 3));
            note_dur    = 8'(k);
        end
        check("hs_done_seen",     got_done, 1);
        check("hs_busy_cycles",   busy_a, 18);
        check("hs_ready_low",     ready_bad, 0);
        check("hs_transitions",   trans_a, 4);
        check("hs_ready_in_done", int'(rdy1), 1);
        note_origin = 14'd16382; note_dur = 8'd1;
        step_clk();
        nv1 = 1'b0;
        check("b2b_busy_next",  int'(busy1), 1);
        check("b2b_done_clear", int'(done1), 0);
        first_b = -1; done_b = -1;
        for (int k = 0; k < 40; k++) begin
            if (k > 0) step_clk();
            if (spk1 && first_b < 0) first_b = k;
            if (done1) begin
                done_b = k;
                break;
            end
        end
        check("b2b_first_toggle", first_b, 2);
        check("b2b_done_sample",  done_b, 18);
        step_clk();

        // Long preset on the PRE_DIV=3 instance: half-period 9 over 3 full periods.
        run_note(1'b1, 14'd16381, 8'd4, 9, 6, 100,
                 first_t, trans, busy_n, done_e, done_n, spacing_bad, spk_end);
        check("long_first_toggle", first_t, 9);
        check("long_spacing_bad",  spacing_bad, 0);
        check("long_transitions",  trans, 8);
        check("long_busy_cycles",  busy_n, 66);
        check("long_done_pulses",  done_n, 1);
        check("long_idle_other",   int'(busy1), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
